// File: rtl/hack_mem_pkg.sv
// Shared defaults and FSM state encoding for the Hack RAM block.
package hack_mem_pkg;

    localparam int unsigned DEF_DATA_W = 16;
    localparam int unsigned DEF_ADDR_W = 15;
    localparam int unsigned DEF_DEPTH  = 24576;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

endpackage

// File: rtl/hack_ram_array.sv
// Storage array: one asynchronous read port, one synchronous read port, one write port.
module hack_ram_array #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned IDX_W  = 4
) (
    input  logic              clk,
    input  logic              we,
    input  logic [IDX_W-1:0]  waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [IDX_W-1:0]  raddr_a,
    output logic [DATA_W-1:0] rdata_a,
    input  logic [IDX_W-1:0]  raddr_b,
    output logic [DATA_W-1:0] rdata_b
);

    logic [DATA_W-1:0] mem [DEPTH];

    // Sync port samples before the write lands, so it returns old data.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        rdata_b <= mem[raddr_b];
    end

    assign rdata_a = mem[raddr_a];

endmodule

// File: rtl/hack_ram.sv
// Hack data RAM: CPU async port, registered video port, clear sweep FSM and fault capture.
module hack_ram
    import hack_mem_pkg::*;
#(
    parameter int unsigned DATA_W         = DEF_DATA_W,
    parameter int unsigned ADDR_W         = DEF_ADDR_W,
    parameter int unsigned DEPTH          = DEF_DEPTH,
    parameter bit          CLEAR_ON_RESET = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_we,
    input  logic              cpu_re,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_din,
    output logic [DATA_W-1:0] cpu_dout,
    input  logic              vid_req,
    input  logic [ADDR_W-1:0] vid_addr,
    output logic [DATA_W-1:0] vid_dout,
    output logic              vid_valid,
    input  logic              clr_req,
    output logic              busy,
    output logic              fault,
    output logic [ADDR_W-1:0] fault_addr,
    input  logic              fault_clr
);

    localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [IDX_W-1:0] LAST = IDX_W'(DEPTH - 1);
    localparam logic [ADDR_W:0]  LIMIT = (ADDR_W + 1)'(DEPTH);

    if (DEPTH == 0 || 64'(DEPTH) > (64'd1 << ADDR_W)) begin : g_depth_chk
        $error("hack_ram: DEPTH must be 1..2**ADDR_W");
    end

    state_t             state, state_next;
    logic [IDX_W-1:0]   clr_cnt;
    logic               init_pend;
    logic               cpu_ok, vid_ok, bad_access;
    logic [IDX_W-1:0]   cpu_idx, vid_idx;
    logic               arr_we;
    logic [IDX_W-1:0]   arr_waddr;
    logic [DATA_W-1:0]  arr_wdata, arr_rdata_a, arr_rdata_b;
    logic               vid_ok_q;

    assign cpu_ok     = {1'b0, cpu_addr} < LIMIT;
    assign vid_ok     = {1'b0, vid_addr} < LIMIT;
    assign cpu_idx    = cpu_ok ? IDX_W'(cpu_addr) : '0;
    assign vid_idx    = vid_ok ? IDX_W'(vid_addr) : '0;
    assign bad_access = (cpu_we | cpu_re) & ~cpu_ok;

    // State register; init_pend requests one sweep on the first edge after reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            init_pend <= CLEAR_ON_RESET;
        end else begin
            state     <= state_next;
            init_pend <= 1'b0;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (clr_req || init_pend) state_next = CLEAR;
            CLEAR:   if (clr_cnt == LAST)      state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Sweep owns the write port while busy; CPU writes are dropped then.
    always_comb begin
        busy      = (state == CLEAR);
        arr_we    = cpu_we & cpu_ok;
        arr_waddr = cpu_idx;
        arr_wdata = cpu_din;
        if (busy) begin
            arr_we    = 1'b1;
            arr_waddr = clr_cnt;
            arr_wdata = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            clr_cnt <= '0;
        end else if (state == CLEAR && clr_cnt != LAST) begin
            clr_cnt <= clr_cnt + IDX_W'(1);
        end else begin
            clr_cnt <= '0;
        end
    end

    // A new fault beats fault_clr and recaptures the address.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fault      <= 1'b0;
            fault_addr <= '0;
        end else if (bad_access) begin
            fault <= 1'b1;
            if (!fault || fault_clr) begin
                fault_addr <= cpu_addr;
            end
        end else if (fault_clr) begin
            fault <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vid_valid <= 1'b0;
            vid_ok_q  <= 1'b0;
        end else begin
            vid_valid <= vid_req;
            vid_ok_q  <= vid_req & vid_ok;
        end
    end

    assign cpu_dout = cpu_ok ? arr_rdata_a : '0;
    assign vid_dout = arr_rdata_b & {DATA_W{vid_ok_q}};

    hack_ram_array #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .IDX_W  (IDX_W)
    ) u_array (
        .clk     (clk),
        .we      (arr_we),
        .waddr   (arr_waddr),
        .wdata   (arr_wdata),
        .raddr_a (cpu_idx),
        .rdata_a (arr_rdata_a),
        .raddr_b (vid_idx),
        .rdata_b (arr_rdata_b)
    );

endmodule

// File: tb/tb_hack_ram.sv
// Directed self-checking bench for hack_ram with DEPTH=16.
module tb_hack_ram;

    localparam int unsigned DW = 16;
    localparam int unsigned AW = 8;
    localparam int unsigned D  = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          cpu_we, cpu_re, vid_req, clr_req, fault_clr;
    logic [AW-1:0] cpu_addr, vid_addr, fault_addr;
    logic [DW-1:0] cpu_din, cpu_dout, vid_dout;
    logic          vid_valid, busy, fault;

    int cmp_cnt = 0;
    int err_cnt = 0;
    int n;

    always #5 clk = ~clk;

    hack_ram #(
        .DATA_W (DW),
        .ADDR_W (AW),
        .DEPTH  (D),
        .CLEAR_ON_RESET (1'b1)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .cpu_we     (cpu_we),
        .cpu_re     (cpu_re),
        .cpu_addr   (cpu_addr),
        .cpu_din    (cpu_din),
        .cpu_dout   (cpu_dout),
        .vid_req    (vid_req),
        .vid_addr   (vid_addr),
        .vid_dout   (vid_dout),
        .vid_valid  (vid_valid),
        .clr_req    (clr_req),
        .busy       (busy),
        .fault      (fault),
        .fault_addr (fault_addr),
        .fault_clr  (fault_clr)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        cmp_cnt++;
        assert (obs === exp) else begin
            err_cnt++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic count_busy(output int cnt);
        cnt = 0;
        while (busy && cnt < 100) begin
            cnt++;
            tick();
        end
    endtask

    task automatic cpu_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
        cpu_we = 1'b1; cpu_addr = a; cpu_din = d;
        tick();
        cpu_we = 1'b0;
    endtask

    task automatic cpu_peek(input logic [AW-1:0] a);
        cpu_addr = a;
        #1;
    endtask

    initial begin
        rst = 1'b1; cpu_we = 1'b0; cpu_re = 1'b0; vid_req = 1'b0; clr_req = 1'b0;
        fault_clr = 1'b0; cpu_addr = '0; vid_addr = '0; cpu_din = '0;
        tick(); tick();
        chk("rst busy", 32'(busy), 0);
        chk("rst fault", 32'(fault), 0);
        chk("rst fault_addr", 32'(fault_addr), 0);
        chk("rst vid_valid", 32'(vid_valid), 0);
        chk("rst vid_dout", 32'(vid_dout), 0);

        rst = 1'b0;
        tick();
        count_busy(n);
        chk("initial sweep len", 32'(n), 16);

        for (int a = 0; a < 16; a++) cpu_write(AW'(a), DW'(16'hA000 + a));
        cpu_peek(3);
        chk("readback a3", 32'(cpu_dout), 32'hA003);

        // Reset pulse re-sweeps and clears the array.
        rst = 1'b1; tick(); rst = 1'b0;
        tick();
        count_busy(n);
        chk("reset sweep len", 32'(n), 16);
        for (int a = 0; a < 16; a++) begin
            cpu_peek(AW'(a));
            chk($sformatf("zero a%0d", a), 32'(cpu_dout), 0);
        end

        cpu_write(5, 16'h1234);
        cpu_write(7, 16'h7777);
        cpu_we = 1'b1; cpu_addr = 5; cpu_din = 16'hBEEF; vid_req = 1'b1; vid_addr = 5;
        #1;
        chk("old data before edge", 32'(cpu_dout), 32'h1234);
        tick();
        cpu_we = 1'b0; vid_req = 1'b0;
        chk("vid old data valid", 32'(vid_valid), 1);
        chk("vid old data", 32'(vid_dout), 32'h1234);
        #1;
        chk("cpu new data", 32'(cpu_dout), 32'hBEEF);
        tick();
        chk("vid pulse one cycle", 32'(vid_valid), 0);

        vid_req = 1'b1; vid_addr = 7;
        tick();
        chk("b2b vid a7", 32'(vid_dout), 32'h7777);
        vid_addr = 5;
        tick();
        chk("b2b vid a5 valid", 32'(vid_valid), 1);
        chk("b2b vid a5", 32'(vid_dout), 32'hBEEF);
        vid_addr = 20;
        tick();
        vid_req = 1'b0;
        chk("vid oor valid", 32'(vid_valid), 1);
        chk("vid oor data", 32'(vid_dout), 0);
        chk("vid oor no fault", 32'(fault), 0);
        cpu_peek(20);
        chk("cpu oor read 0", 32'(cpu_dout), 0);

        cpu_write(D + 3, 16'hDEAD);
        chk("fault set", 32'(fault), 1);
        chk("fault_addr first", 32'(fault_addr), D + 3);
        cpu_peek(3);
        chk("oor write no alias", 32'(cpu_dout), 0);
        cpu_re = 1'b1; cpu_addr = D + 7;
        tick();
        cpu_re = 1'b0;
        chk("fault_addr sticky", 32'(fault_addr), D + 3);

        fault_clr = 1'b1; cpu_re = 1'b1; cpu_addr = D + 1;
        tick();
        fault_clr = 1'b0; cpu_re = 1'b0;
        chk("clr vs new fault", 32'(fault), 1);
        chk("clr vs new addr", 32'(fault_addr), D + 1);
        fault_clr = 1'b1;
        tick();
        fault_clr = 1'b0;
        chk("fault cleared", 32'(fault), 0);

        // clr_req and a CPU write mid-sweep must not restart or leak.
        cpu_write(2, 16'h2222);
        clr_req = 1'b1;
        tick();
        clr_req = 1'b0;
        n = 0;
        while (busy && n < 100) begin
            n++;
            if (n == 5) begin
                clr_req = 1'b1; cpu_we = 1'b1; cpu_addr = 2; cpu_din = 16'hFFFF;
            end else begin
                clr_req = 1'b0; cpu_we = 1'b0;
            end
            tick();
        end
        clr_req = 1'b0; cpu_we = 1'b0;
        chk("sweep len w/ clr_req", 32'(n), 16);
        cpu_peek(2);
        chk("dropped write a2", 32'(cpu_dout), 0);
        cpu_peek(7);
        chk("swept a7", 32'(cpu_dout), 0);
        chk("no fault in sweep", 32'(fault), 0);
        tick();
        chk("idle after sweep", 32'(busy), 0);

        // Reset mid-sweep aborts immediately, then a full sweep runs.
        cpu_write(9, 16'h9999);
        cpu_re = 1'b1; cpu_addr = 30;
        tick();
        cpu_re = 1'b0;
        chk("fault before abort", 32'(fault), 1);
        clr_req = 1'b1;
        tick();
        clr_req = 1'b0;
        tick(); tick();
        rst = 1'b1;
        #1;
        chk("busy drops on rst", 32'(busy), 0);
        chk("fault reset", 32'(fault), 0);
        chk("fault_addr reset", 32'(fault_addr), 0);
        tick();
        rst = 1'b0;
        tick();
        vid_req = 1'b1; vid_addr = 9;
        tick();
        vid_req = 1'b0;
        chk("vid during busy valid", 32'(vid_valid), 1);
        chk("vid during busy data", 32'(vid_dout), 32'h9999);
        count_busy(n);
        chk("sweep after abort", 32'(n), 15);
        cpu_peek(9);
        chk("a9 swept", 32'(cpu_dout), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
        $finish;
    end

endmodule
